// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcodes
// and the datapath mux select codes.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_FETCH   = 4'd1,
        ST_DECODE  = 4'd2,
        ST_MEMADR  = 4'd3,
        ST_MEMRD   = 4'd4,
        ST_MEMWB   = 4'd5,
        ST_MEMWR   = 4'd6,
        ST_EXEC_R  = 4'd7,
        ST_ALU_WB  = 4'd8,
        ST_JR      = 4'd9,
        ST_BRANCH  = 4'd10,
        ST_IMM_EX  = 4'd11,
        ST_IMM_WB  = 4'd12,
        ST_JUMP    = 4'd13,
        ST_ILLEGAL = 4'd14
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;
    localparam logic [1:0] ALUOP_OR   = 2'b11;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_RS     = 2'b11;

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Shared memory port between the control FSM (master) and the memory (slave).
interface mips_multicycle_control_if;
    logic mem_req;
    logic mem_we;
    logic iord;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output iord, input mem_ready);
    modport slave  (input mem_req, input mem_we, input iord, output mem_ready);
endinterface

// File: rtl/mips_ctrl_outdec.sv
// Combinational strobe decoder: state plus the few same-cycle inputs that
// feed Mealy outputs (FETCH handshake, BRANCH zero flag).
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    input  logic       zero,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] aluop,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       illegal_op
);
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        aluop      = ALUOP_ADD;
        pc_src     = PCSRC_ALU;
        pc_en      = 1'b0;
        illegal_op = 1'b0;
        case (state)
            ST_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
            end
            ST_DECODE:  alu_src_b = SRCB_IMM_SH;
            ST_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            ST_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            ST_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            ST_MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
            end
            ST_EXEC_R: begin
                alu_src_a = 1'b1;
                aluop     = ALUOP_FUNC;
            end
            ST_ALU_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            ST_JR: begin
                pc_src = PCSRC_RS;
                pc_en  = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a = 1'b1;
                aluop     = ALUOP_SUB;
                pc_src    = PCSRC_ALUOUT;
                pc_en     = zero;
            end
            ST_IMM_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                aluop     = (opcode == OP_ORI) ? ALUOP_OR : ALUOP_ADD;
            end
            ST_IMM_WB:  reg_write = 1'b1;
            ST_JUMP: begin
                pc_src = PCSRC_JUMP;
                pc_en  = 1'b1;
            end
            ST_ILLEGAL: illegal_op = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS32 datapath: state register and
// next-state logic; strobes come from mips_ctrl_outdec.
module mips_multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [5:0]                        opcode,
    input  logic                              jr,
    input  logic                              zero,
    mips_multicycle_control_if.master         mem,
    output logic                              ir_write,
    output logic                              reg_dst,
    output logic                              mem_to_reg,
    output logic                              reg_write,
    output logic                              alu_src_a,
    output logic [1:0]                        alu_src_b,
    output logic [1:0]                        aluop,
    output logic [1:0]                        pc_src,
    output logic                              pc_en,
    output logic                              illegal_op,
    output logic [3:0]                        state
);
    state_t state_q, state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = ST_FETCH;
            ST_FETCH:  if (mem.mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    OP_R:           state_d = ST_EXEC_R;
                    OP_LW, OP_SW:   state_d = ST_MEMADR;
                    OP_BEQ:         state_d = ST_BRANCH;
                    OP_ADDI, OP_ORI: state_d = ST_IMM_EX;
                    OP_J:           state_d = ST_JUMP;
                    default:        state_d = ST_ILLEGAL;
                endcase
            end
            ST_MEMADR: state_d = (opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD:  if (mem.mem_ready) state_d = ST_MEMWB;
            ST_MEMWR:  if (mem.mem_ready) state_d = ST_FETCH;
            ST_EXEC_R: state_d = jr ? ST_JR : ST_ALU_WB;
            ST_IMM_EX: state_d = ST_IMM_WB;
            ST_MEMWB, ST_ALU_WB, ST_JR, ST_BRANCH,
            ST_IMM_WB, ST_JUMP, ST_ILLEGAL: state_d = ST_FETCH;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign state = state_q;

    mips_ctrl_outdec u_outdec (
        .state      (state_q),
        .opcode     (opcode),
        .mem_ready  (mem.mem_ready),
        .zero       (zero),
        .mem_req    (mem.mem_req),
        .mem_we     (mem.mem_we),
        .iord       (mem.iord),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .aluop      (aluop),
        .pc_src     (pc_src),
        .pc_en      (pc_en),
        .illegal_op (illegal_op)
    );
endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: instruction-level reference sequences
// with randomized memory wait states and zero flag.
module tb_mips_multicycle_control;
    import mips_ctrl_pkg::*;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] aluop;
        logic [1:0] pc_src;
        logic       pc_en;
        logic       illegal_op;
    } outs_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       jr;
    logic       zero;
    logic       ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, aluop, pc_src;
    logic       pc_en, illegal_op;
    logic [3:0] state;

    mips_multicycle_control_if mif ();

    mips_multicycle_control dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .jr         (jr),
        .zero       (zero),
        .mem        (mif),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .aluop      (aluop),
        .pc_src     (pc_src),
        .pc_en      (pc_en),
        .illegal_op (illegal_op),
        .state      (state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rdy_q[$];
    int force_zero = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic outs_t observed();
        return {mif.mem_req, mif.mem_we, mif.iord, ir_write, reg_dst, mem_to_reg,
                reg_write, alu_src_a, alu_src_b, aluop, pc_src, pc_en, illegal_op};
    endfunction

    // One FSM state visit; repeats while a memory-wait state sees mem_ready low.
    // kind 1: FETCH handshake strobes, kind 2: BRANCH pc_en follows zero.
    task automatic phase(input state_t st, input outs_t base, input bit wait_mem,
                         input int kind, inout int cyc, inout int waits);
        bit    done = 1'b0;
        int    n = 0;
        outs_t exp;
        while (!done) begin
            @(negedge clk);
            if (rdy_q.size() > 0) mif.mem_ready = (rdy_q.pop_front() != 0);
            else if (n >= 8)      mif.mem_ready = 1'b1;
            else                  mif.mem_ready = ($urandom_range(0, 99) < 65);
            zero = (force_zero >= 0) ? (force_zero != 0) : 1'($urandom_range(0, 1));
            #1;
            exp = base;
            if (kind == 1 && mif.mem_ready) begin
                exp.ir_write = 1'b1;
                exp.pc_en    = 1'b1;
            end
            if (kind == 2) exp.pc_en = zero;
            chk($sformatf("state_%s", st.name()), state, st);
            chk($sformatf("outs_%s", st.name()), observed(), exp);
            chk("regwrite_memwe_excl", {31'd0, reg_write & mif.mem_we}, 32'd0);
            cyc++;
            n++;
            done = !wait_mem || mif.mem_ready;
            if (!done) waits++;
        end
    endtask

    function automatic int base_cycles(input logic [5:0] op);
        case (op)
            OP_R, OP_SW, OP_ADDI, OP_ORI: return 4;
            OP_LW:                        return 5;
            OP_BEQ, OP_J:                 return 3;
            default:                      return 3;
        endcase
    endfunction

    task automatic run_instr(input logic [5:0] op, input logic jrv, output int total);
        int cyc = 0;
        int waits = 0;
        opcode = op;
        jr     = jrv;
        phase(ST_FETCH,  outs_t'{mem_req: 1'b1, alu_src_b: 2'b01, default: '0}, 1, 1, cyc, waits);
        phase(ST_DECODE, outs_t'{alu_src_b: 2'b11, default: '0}, 0, 0, cyc, waits);
        case (op)
            OP_R: begin
                phase(ST_EXEC_R, outs_t'{alu_src_a: 1'b1, aluop: 2'b10, default: '0}, 0, 0, cyc, waits);
                if (jrv) phase(ST_JR, outs_t'{pc_src: 2'b11, pc_en: 1'b1, default: '0}, 0, 0, cyc, waits);
                else     phase(ST_ALU_WB, outs_t'{reg_write: 1'b1, reg_dst: 1'b1, default: '0}, 0, 0, cyc, waits);
            end
            OP_LW, OP_SW: begin
                phase(ST_MEMADR, outs_t'{alu_src_a: 1'b1, alu_src_b: 2'b10, default: '0}, 0, 0, cyc, waits);
                if (op == OP_LW) begin
                    phase(ST_MEMRD, outs_t'{mem_req: 1'b1, iord: 1'b1, default: '0}, 1, 0, cyc, waits);
                    phase(ST_MEMWB, outs_t'{reg_write: 1'b1, mem_to_reg: 1'b1, default: '0}, 0, 0, cyc, waits);
                end else begin
                    phase(ST_MEMWR, outs_t'{mem_req: 1'b1, mem_we: 1'b1, iord: 1'b1, default: '0}, 1, 0, cyc, waits);
                end
            end
            OP_BEQ:
                phase(ST_BRANCH, outs_t'{alu_src_a: 1'b1, aluop: 2'b01, pc_src: 2'b01, default: '0}, 0, 2, cyc, waits);
            OP_ADDI, OP_ORI: begin
                phase(ST_IMM_EX, outs_t'{alu_src_a: 1'b1, alu_src_b: 2'b10,
                                         aluop: (op == OP_ORI) ? 2'b11 : 2'b00, default: '0}, 0, 0, cyc, waits);
                phase(ST_IMM_WB, outs_t'{reg_write: 1'b1, default: '0}, 0, 0, cyc, waits);
            end
            OP_J:
                phase(ST_JUMP, outs_t'{pc_src: 2'b10, pc_en: 1'b1, default: '0}, 0, 0, cyc, waits);
            default:
                phase(ST_ILLEGAL, outs_t'{illegal_op: 1'b1, default: '0}, 0, 0, cyc, waits);
        endcase
        chk($sformatf("cycles_op%06b", op), cyc - waits, base_cycles(op));
        total = cyc;
    endtask

    function automatic logic [5:0] random_op();
        logic [5:0] legal [7] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ORI, OP_J};
        logic [5:0] op;
        if ($urandom_range(0, 7) != 0) return legal[$urandom_range(0, 6)];
        op = 6'($urandom);
        while (op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ORI, OP_J}) op = 6'($urandom);
        return op;
    endfunction

    initial begin
        int total;
        int cyc;
        int waits;
        logic [5:0] op;
        rst_n = 1'b0;
        opcode = 6'd0;
        jr = 1'b0;
        zero = 1'b1;
        mif.mem_ready = 1'b1;
        #12;
        chk("reset_state", state, 32'd0);
        chk("reset_outs", observed(), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        cyc = 0;
        waits = 0;
        phase(ST_IDLE, '0, 0, 0, cyc, waits);

        // R-type add with ready memory
        rdy_q = '{1, 1, 1, 1};
        run_instr(OP_R, 1'b0, total);
        chk("add_total", total, 32'd4);

        // lw with two wait cycles in MEMRD
        rdy_q = '{1, 1, 1, 0, 0, 1, 1};
        run_instr(OP_LW, 1'b0, total);
        chk("lw_wait_total", total, 32'd7);

        force_zero = 1;
        run_instr(OP_BEQ, 1'b0, total);
        force_zero = 0;
        run_instr(OP_BEQ, 1'b0, total);
        force_zero = -1;

        run_instr(OP_R, 1'b1, total);
        run_instr(6'b111111, 1'b0, total);

        // Reset asserted while MEMWR is waiting
        opcode = OP_SW;
        jr = 1'b0;
        cyc = 0;
        rdy_q = '{1, 1, 1};
        phase(ST_FETCH,  outs_t'{mem_req: 1'b1, alu_src_b: 2'b01, default: '0}, 1, 1, cyc, waits);
        phase(ST_DECODE, outs_t'{alu_src_b: 2'b11, default: '0}, 0, 0, cyc, waits);
        phase(ST_MEMADR, outs_t'{alu_src_a: 1'b1, alu_src_b: 2'b10, default: '0}, 0, 0, cyc, waits);
        @(negedge clk);
        mif.mem_ready = 1'b0;
        #1;
        chk("memwr_state", state, ST_MEMWR);
        chk("memwr_we", {30'd0, mif.mem_req, mif.mem_we}, 32'd3);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async_req_we", {30'd0, mif.mem_req, mif.mem_we}, 32'd0);
        chk("rst_async_state", state, 32'd0);
        @(posedge clk);
        #2;
        chk("rst_hold_outs", observed(), 32'd0);
        rst_n = 1'b1;
        phase(ST_IDLE, '0, 0, 0, cyc, waits);

        for (int i = 0; i < 150; i++) begin
            op = random_op();
            run_instr(op, (op == OP_R) ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 1)), total);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
